// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 definitions for the fetch stage.
// Contents: icode constants, status codes, the "no register" encoding,
// the fetch FSM state enum and small decode helpers (instruction length,
// register-byte presence).
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd0;
  localparam logic [2:0] STAT_HLT = 3'd1;
  localparam logic [2:0] STAT_ADR = 3'd2;
  localparam logic [2:0] STAT_INS = 3'd3;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    ST_LINE0 = 2'd0,
    ST_LINE1 = 2'd1,
    ST_VALID = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  // Byte length of an instruction; unknown icodes count as one byte.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    case (icode)
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: instr_len = 4'd2;
      I_JXX, I_CALL:                    instr_len = 4'd9;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:     instr_len = 4'd10;
      default:                          instr_len = 4'd1;
    endcase
  endfunction

  // True when the instruction carries an rA:rB register byte.
  function automatic logic has_regs(input logic [3:0] icode);
    case (icode)
      I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
      I_OPQ, I_PUSHQ, I_POPQ:           has_regs = 1'b1;
      default:                          has_regs = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_align.sv
// instr_align: combinational instruction splitter.
// Ports: win (16-byte window, byte 0 in bits [7:0]), off (pc[2:0]) in;
//        icode, ifun, ra, rb, valc, len, need_line1 out.
// Bytes past the end of the window read as zero.
module instr_align
  import y86_pkg::*;
(
  input  logic [127:0] win,
  input  logic [2:0]   off,
  output logic [3:0]   icode,
  output logic [3:0]   ifun,
  output logic [3:0]   ra,
  output logic [3:0]   rb,
  output logic [63:0]  valc,
  output logic [3:0]   len,
  output logic         need_line1
);

  logic [79:0] b_s;

  // Bring the instruction's first byte down to bit 0; only 10 bytes matter.
  assign b_s = 80'(win >> {off, 3'b000});

  // Field split, length and straddle detection.
  always_comb begin
    icode = b_s[7:4];
    ifun  = b_s[3:0];
    len   = instr_len(b_s[7:4]);
    if (has_regs(b_s[7:4])) begin
      ra = b_s[15:12];
      rb = b_s[11:8];
    end else begin
      ra = REG_NONE;
      rb = REG_NONE;
    end
    case (b_s[7:4])
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: valc = b_s[79:16];
      I_JXX, I_CALL:                valc = b_s[71:8];
      default:                      valc = 64'h0;
    endcase
    need_line1 = ({2'b00, off} + {1'b0, len}) > 5'd8;
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: Y86-64 fetch stage feeding decode_reg.
// Ports: clk, rst (async active-low); F_stall_i; M/W redirect inputs;
//        imem_req_o/imem_addr_o (8-aligned line request) and
//        imem_ack_i/imem_rdata_i/imem_err_i response; f_valid_o plus the
//        registered instruction fields f_icode_o .. f_stat_o.
// Option: FETCH_LINEBUF_EN adds a one-entry line buffer that short-cuts
//         repeated fetches from the most recently received line.
module fetch_stage
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        F_stall_i,
  input  logic [3:0]  M_icode_i,
  input  logic        M_Cnd_i,
  input  logic [63:0] M_valA_i,
  input  logic [3:0]  W_icode_i,
  input  logic [63:0] W_valM_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [63:0] imem_rdata_i,
  input  logic        imem_err_i,
  output logic        f_valid_o,
  output logic [3:0]  f_icode_o,
  output logic [3:0]  f_ifun_o,
  output logic [3:0]  f_rA_o,
  output logic [3:0]  f_rB_o,
  output logic [63:0] f_valC_o,
  output logic [63:0] f_valP_o,
  output logic [2:0]  f_stat_o
);

  fetch_state_e state_r, nxt_state_s;
  logic [63:0]  pc_r, nxt_pc_s, line0_r, pend_tgt_r, nxt_pend_tgt_s, pred_r, addr_r;
  logic         pend_r, nxt_pend_s, req_r, load_s, save_line0_s;
  logic         redir_m_s, redir_w_s, redir_s, accept_s, line_st_s, got_s, err_s;
  logic [63:0]  redir_tgt_s, data_s;
  logic [127:0] win_s;
  logic [3:0]   a_icode_s, a_ifun_s, a_ra_s, a_rb_s, a_len_s;
  logic [63:0]  a_valc_s;
  logic         a_need_line1_s;
  logic [3:0]   fld_icode_s, fld_ifun_s, fld_ra_s, fld_rb_s;
  logic [63:0]  fld_valc_s, fld_valp_s, fld_pred_s;
  logic [2:0]   fld_stat_s;

  // M (mispredicted branch) outranks W (ret) when both fire.
  assign redir_m_s   = (M_icode_i == I_JXX) && !M_Cnd_i;
  assign redir_w_s   = (W_icode_i == I_RET);
  assign redir_s     = redir_m_s || redir_w_s;
  assign redir_tgt_s = redir_m_s ? M_valA_i : W_valM_i;
  assign accept_s    = f_valid_o && !F_stall_i;
  assign line_st_s   = (state_r == ST_LINE0) || (state_r == ST_LINE1);
  assign imem_addr_o = addr_r;

`ifdef FETCH_LINEBUF_EN
  logic        buf_v_r, hit_s;
  logic [60:0] buf_tag_r;
  logic [63:0] buf_data_r;

  // A hit is treated exactly like an ack arriving this cycle.
  assign hit_s      = line_st_s && buf_v_r && (buf_tag_r == addr_r[63:3]);
  assign imem_req_o = req_r && !hit_s;
  assign got_s      = hit_s || (imem_req_o && imem_ack_i);
  assign data_s     = hit_s ? buf_data_r : imem_rdata_i;
  assign err_s      = !hit_s && imem_err_i;

  // Line buffer: remember the last error-free line returned by memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_v_r    <= 1'b0;
      buf_tag_r  <= 61'h0;
      buf_data_r <= 64'h0;
    end else if (imem_req_o && imem_ack_i && !imem_err_i) begin
      buf_v_r    <= 1'b1;
      buf_tag_r  <= addr_r[63:3];
      buf_data_r <= imem_rdata_i;
    end
  end
`else
  assign imem_req_o = req_r;
  assign got_s      = req_r && imem_ack_i;
  assign data_s     = imem_rdata_i;
  assign err_s      = imem_err_i;
`endif

  // Second line only ever follows a first line that was kept in line0_r.
  assign win_s = (state_r == ST_LINE1) ? {data_s, line0_r} : {64'h0, data_s};

  instr_align u_align (
    .win        (win_s),
    .off        (pc_r[2:0]),
    .icode      (a_icode_s),
    .ifun       (a_ifun_s),
    .ra         (a_ra_s),
    .rb         (a_rb_s),
    .valc       (a_valc_s),
    .len        (a_len_s),
    .need_line1 (a_need_line1_s)
  );

  // Fields to present: a bus error turns the fetch into an ADR nop.
  always_comb begin
    fld_icode_s = a_icode_s;
    fld_ifun_s  = a_ifun_s;
    fld_ra_s    = a_ra_s;
    fld_rb_s    = a_rb_s;
    fld_valc_s  = a_valc_s;
    fld_valp_s  = pc_r + {60'h0, a_len_s};
    fld_stat_s  = STAT_AOK;
    if (err_s) begin
      fld_icode_s = I_NOP;
      fld_ifun_s  = 4'h0;
      fld_ra_s    = REG_NONE;
      fld_rb_s    = REG_NONE;
      fld_valc_s  = 64'h0;
      fld_valp_s  = pc_r;
      fld_stat_s  = STAT_ADR;
    end else if (a_icode_s == I_HALT) begin
      fld_stat_s  = STAT_HLT;
    end else if (a_icode_s > I_POPQ) begin
      fld_stat_s  = STAT_INS;
    end else begin
      fld_stat_s  = STAT_AOK;
    end
    if ((fld_icode_s == I_JXX) || (fld_icode_s == I_CALL)) begin
      fld_pred_s = fld_valc_s;
    end else begin
      fld_pred_s = fld_valp_s;
    end
  end

  // Next-state logic for the fetch FSM, pending redirect and PC.
  always_comb begin
    nxt_state_s    = state_r;
    nxt_pc_s       = pc_r;
    nxt_pend_s     = pend_r;
    nxt_pend_tgt_s = pend_tgt_r;
    load_s         = 1'b0;
    save_line0_s   = 1'b0;
    case (state_r)
      ST_LINE0, ST_LINE1: begin
        if (redir_s || pend_r) begin
          // An outstanding request must complete before restarting.
          if (got_s || !imem_req_o) begin
            nxt_state_s = ST_LINE0;
            nxt_pc_s    = redir_s ? redir_tgt_s : pend_tgt_r;
            nxt_pend_s  = 1'b0;
          end else begin
            nxt_pend_s     = 1'b1;
            nxt_pend_tgt_s = redir_s ? redir_tgt_s : pend_tgt_r;
          end
        end else if (got_s) begin
          if (!err_s && (state_r == ST_LINE0) && a_need_line1_s) begin
            save_line0_s = 1'b1;
            nxt_state_s  = ST_LINE1;
          end else begin
            load_s      = 1'b1;
            nxt_state_s = ST_VALID;
          end
        end else begin
          nxt_state_s = state_r;
        end
      end
      ST_VALID: begin
        if (redir_s) begin
          nxt_state_s = ST_LINE0;
          nxt_pc_s    = redir_tgt_s;
        end else if (accept_s) begin
          nxt_state_s = (f_stat_o != STAT_AOK) ? ST_HALT : ST_LINE0;
          nxt_pc_s    = pred_r;
        end else begin
          nxt_state_s = ST_VALID;
        end
      end
      ST_HALT: begin
        if (redir_s) begin
          nxt_state_s = ST_LINE0;
          nxt_pc_s    = redir_tgt_s;
        end else begin
          nxt_state_s = ST_HALT;
        end
      end
      default: begin
        nxt_state_s = ST_LINE0;
        nxt_pc_s    = RESET_PC;
      end
    endcase
  end

  // FSM state, PC, pending redirect and the registered request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_LINE0;
      pc_r       <= RESET_PC;
      pend_r     <= 1'b0;
      pend_tgt_r <= 64'h0;
      req_r      <= 1'b0;
      addr_r     <= {RESET_PC[63:3], 3'b000};
      line0_r    <= 64'h0;
    end else begin
      state_r    <= nxt_state_s;
      pc_r       <= nxt_pc_s;
      pend_r     <= nxt_pend_s;
      pend_tgt_r <= nxt_pend_tgt_s;
      req_r      <= (nxt_state_s == ST_LINE0) || (nxt_state_s == ST_LINE1);
      addr_r     <= {nxt_pc_s[63:3], 3'b000} + ((nxt_state_s == ST_LINE1) ? 64'd8 : 64'd0);
      if (save_line0_s) begin
        line0_r <= data_s;
      end
    end
  end

  // Presented instruction and its predicted successor PC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_valid_o <= 1'b0;
      f_icode_o <= I_NOP;
      f_ifun_o  <= 4'h0;
      f_rA_o    <= REG_NONE;
      f_rB_o    <= REG_NONE;
      f_valC_o  <= 64'h0;
      f_valP_o  <= 64'h0;
      f_stat_o  <= STAT_AOK;
      pred_r    <= 64'h0;
    end else begin
      f_valid_o <= (nxt_state_s == ST_VALID);
      if (load_s) begin
        f_icode_o <= fld_icode_s;
        f_ifun_o  <= fld_ifun_s;
        f_rA_o    <= fld_ra_s;
        f_rB_o    <= fld_rb_s;
        f_valC_o  <= fld_valc_s;
        f_valP_o  <= fld_valp_s;
        f_stat_o  <= fld_stat_s;
        pred_r    <= fld_pred_s;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a byte-array memory
// that answers line requests on the falling edge (zero-wait ack).
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        F_stall_i;
  logic [3:0]  M_icode_i, W_icode_i;
  logic        M_Cnd_i;
  logic [63:0] M_valA_i, W_valM_i;
  logic        imem_req_o, imem_ack_i, imem_err_i;
  logic [63:0] imem_addr_o, imem_rdata_i;
  logic        f_valid_o;
  logic [3:0]  f_icode_o, f_ifun_o, f_rA_o, f_rB_o;
  logic [63:0] f_valC_o, f_valP_o;
  logic [2:0]  f_stat_o;

  logic [7:0]  mem [0:255];
  logic [63:0] req_log [$];
  logic        ack_en;
  logic [63:0] err_line;
  int          n_vec = 0;
  int          n_err = 0;
  int          mark;

  fetch_stage #(.RESET_PC(64'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .F_stall_i    (F_stall_i),
    .M_icode_i    (M_icode_i),
    .M_Cnd_i      (M_Cnd_i),
    .M_valA_i     (M_valA_i),
    .W_icode_i    (W_icode_i),
    .W_valM_i     (W_valM_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .imem_err_i   (imem_err_i),
    .f_valid_o    (f_valid_o),
    .f_icode_o    (f_icode_o),
    .f_ifun_o     (f_ifun_o),
    .f_rA_o       (f_rA_o),
    .f_rB_o       (f_rB_o),
    .f_valC_o     (f_valC_o),
    .f_valP_o     (f_valP_o),
    .f_stat_o     (f_stat_o)
  );

  always #5 clk = ~clk;

  task automatic chk_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] line_of(input logic [7:0] a);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = mem[int'(a) + i];
    return r;
  endfunction

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!f_valid_o && n < 60);
    chk_vec({tag, "_valid"}, 64'(f_valid_o), 64'h1);
  endtask

  // Memory responder: acks any request on the falling edge, logs the address.
  initial begin
    imem_ack_i = 1'b0; imem_err_i = 1'b0; imem_rdata_i = 64'h0;
    forever begin
      @(negedge clk);
      if (rst && imem_req_o && ack_en) begin
        imem_ack_i   = 1'b1;
        imem_rdata_i = line_of(imem_addr_o[7:0]);
        imem_err_i   = (imem_addr_o == err_line);
        req_log.push_back(imem_addr_o);
      end else begin
        imem_ack_i = 1'b0;
        imem_err_i = 1'b0;
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    // 0x00 irmovq $2,%rsp ; 0x0A nop ; 0x0B jmp 0x40
    mem[0] = 8'h30; mem[1] = 8'hF4; mem[2] = 8'h02;
    mem[10] = 8'h10; mem[11] = 8'h70; mem[12] = 8'h40;
    // 0x80 rrmovq %rcx,%rdx ; 0x82 jmp 0x90
    mem[128] = 8'h20; mem[129] = 8'h12; mem[130] = 8'h70; mem[131] = 8'h90;
    // 0x30 nop ; 0x31 nop ; 0x32 halt
    mem[48] = 8'h10; mem[49] = 8'h10;
    rst = 1'b0; F_stall_i = 1'b1; ack_en = 1'b1; err_line = 64'hFFFF_FFFF_FFFF_FFF8;
    M_icode_i = 4'h0; M_Cnd_i = 1'b0; M_valA_i = 64'h0; W_icode_i = 4'h0; W_valM_i = 64'h0;

    repeat (3) @(negedge clk);
    chk_vec("rst_req", 64'(imem_req_o), 64'h0);
    chk_vec("rst_valid", 64'(f_valid_o), 64'h0);
    chk_vec("rst_icode", 64'(f_icode_o), 64'h1);
    chk_vec("rst_ifun", 64'(f_ifun_o), 64'h0);
    chk_vec("rst_rA", 64'(f_rA_o), 64'hF);
    chk_vec("rst_rB", 64'(f_rB_o), 64'hF);
    chk_vec("rst_valC", f_valC_o, 64'h0);
    chk_vec("rst_valP", f_valP_o, 64'h0);
    chk_vec("rst_stat", 64'(f_stat_o), 64'h0);
    rst = 1'b1;
    @(negedge clk);
    chk_vec("first_req", 64'(imem_req_o), 64'h1);
    chk_vec("first_addr", imem_addr_o, 64'h0);

    // irmovq straddles lines 0 and 8
    wait_valid("irmov");
    chk_vec("irmov_icode", 64'(f_icode_o), 64'h3);
    chk_vec("irmov_rA", 64'(f_rA_o), 64'hF);
    chk_vec("irmov_rB", 64'(f_rB_o), 64'h4);
    chk_vec("irmov_valC", f_valC_o, 64'h2);
    chk_vec("irmov_valP", f_valP_o, 64'hA);
    chk_vec("irmov_stat", 64'(f_stat_o), 64'h0);
    chk_vec("irmov_nreq", 64'(req_log.size()), 64'h2);
    chk_vec("irmov_req0", req_log[0], 64'h0);
    chk_vec("irmov_req1", req_log[1], 64'h8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_vec("stall_valid", 64'(f_valid_o), 64'h1);
      chk_vec("stall_valC", f_valC_o, 64'h2);
      chk_vec("stall_req", 64'(imem_req_o), 64'h0);
    end
    F_stall_i = 1'b0;

    wait_valid("nop");
    chk_vec("nop_icode", 64'(f_icode_o), 64'h1);
    chk_vec("nop_valP", f_valP_o, 64'hB);
    chk_vec("nop_lastreq", req_log[req_log.size()-1], 64'h8);

    wait_valid("jmp");
    chk_vec("jmp_icode", 64'(f_icode_o), 64'h7);
    chk_vec("jmp_rA", 64'(f_rA_o), 64'hF);
    chk_vec("jmp_valC", f_valC_o, 64'h40);
    chk_vec("jmp_valP", f_valP_o, 64'h14);
    ack_en = 1'b0;
    mark = req_log.size();

    // Redirect while the request to 0x40 is held
    repeat (3) @(negedge clk);
    chk_vec("hold_req", 64'(imem_req_o), 64'h1);
    chk_vec("hold_addr", imem_addr_o, 64'h40);
    M_icode_i = 4'h7; M_Cnd_i = 1'b0; M_valA_i = 64'h80;
    @(negedge clk);
    M_icode_i = 4'h0; M_valA_i = 64'h0;
    repeat (2) @(negedge clk);
    chk_vec("held_req", 64'(imem_req_o), 64'h1);
    chk_vec("held_addr", imem_addr_o, 64'h40);
    ack_en = 1'b1;
    wait_valid("rr");
    chk_vec("rr_icode", 64'(f_icode_o), 64'h2);
    chk_vec("rr_rA", 64'(f_rA_o), 64'h1);
    chk_vec("rr_rB", 64'(f_rB_o), 64'h2);
    chk_vec("rr_valP", f_valP_o, 64'h82);
    chk_vec("redir_nreq", 64'(req_log.size() - mark), 64'h2);
    chk_vec("redir_req0", req_log[mark], 64'h40);
    chk_vec("redir_req1", req_log[mark+1], 64'h80);

    wait_valid("jmp2");
    chk_vec("jmp2_valC", f_valC_o, 64'h90);
    chk_vec("jmp2_valP", f_valP_o, 64'h8B);
    err_line = 64'h90;

    // Bus error at 0x90, then halt until a ret redirect
    wait_valid("adr");
    chk_vec("adr_icode", 64'(f_icode_o), 64'h1);
    chk_vec("adr_stat", 64'(f_stat_o), 64'h2);
    err_line = 64'hFFFF_FFFF_FFFF_FFF8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_vec("halt_valid", 64'(f_valid_o), 64'h0);
      chk_vec("halt_req", 64'(imem_req_o), 64'h0);
    end
    W_icode_i = 4'h9; W_valM_i = 64'h20;
    @(negedge clk);
    W_icode_i = 4'h0; W_valM_i = 64'h0;
    wait_valid("hlt");
    chk_vec("hlt_icode", 64'(f_icode_o), 64'h0);
    chk_vec("hlt_stat", 64'(f_stat_o), 64'h1);
    chk_vec("hlt_valP", f_valP_o, 64'h21);
    chk_vec("hlt_lastreq", req_log[req_log.size()-1], 64'h20);
    @(negedge clk);

    // rmmovq at pc=6 spanning lines 0 and 8
    mem[6] = 8'h40; mem[7] = 8'h37;
    for (int i = 0; i < 8; i++) mem[8+i] = 8'(8'h11 * (i + 1));
    mark = req_log.size();
    M_icode_i = 4'h7; M_Cnd_i = 1'b0; M_valA_i = 64'h6;
    @(negedge clk);
    M_icode_i = 4'h0; M_valA_i = 64'h0;
    wait_valid("rmmov");
    chk_vec("rmmov_icode", 64'(f_icode_o), 64'h4);
    chk_vec("rmmov_rA", 64'(f_rA_o), 64'h3);
    chk_vec("rmmov_rB", 64'(f_rB_o), 64'h7);
    chk_vec("rmmov_valC", f_valC_o, 64'h8877665544332211);
    chk_vec("rmmov_valP", f_valP_o, 64'h10);
    chk_vec("rmmov_stat", 64'(f_stat_o), 64'h0);
    chk_vec("rmmov_req0", req_log[mark], 64'h0);
    chk_vec("rmmov_req1", req_log[mark+1], 64'h8);
    wait_valid("hlt2");
    chk_vec("hlt2_stat", 64'(f_stat_o), 64'h1);
    @(negedge clk);

    // Three sequential fetches from line 0x30
    mark = req_log.size();
    W_icode_i = 4'h9; W_valM_i = 64'h30;
    @(negedge clk);
    W_icode_i = 4'h0; W_valM_i = 64'h0;
    wait_valid("seq0");
    chk_vec("seq0_valP", f_valP_o, 64'h31);
    wait_valid("seq1");
    chk_vec("seq1_icode", 64'(f_icode_o), 64'h1);
    chk_vec("seq1_valP", f_valP_o, 64'h32);
    wait_valid("seq2");
    chk_vec("seq2_icode", 64'(f_icode_o), 64'h0);
`ifdef FETCH_LINEBUF_EN
    chk_vec("seq_nreq", 64'(req_log.size() - mark), 64'h1);
`else
    chk_vec("seq_nreq", 64'(req_log.size() - mark), 64'h3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
